// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: widths, register count and the hard-wired zero register.
package mips_pkg;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned REG_ZERO  = 0;
endpackage

// File: rtl/mips_register_file_if.sv
// Register-file port bundle: one write port and two read ports.
interface mips_register_file_if #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W
);
  logic              reg_write;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;

  modport master (
    output reg_write, write_reg, write_data, read_reg1, read_reg2,
    input  read_data1, read_data2
  );

  modport slave (
    input  reg_write, write_reg, write_data, read_reg1, read_reg2,
    output read_data1, read_data2
  );
endinterface

// File: rtl/mips_register_file_decoder.sv
// One-hot write-enable decode; register zero never receives an enable.
module decoder_5_to_32
  import mips_pkg::REG_ZERO;
#(
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) (
  input  logic                 en,
  input  logic [ADDR_W-1:0]    addr,
  output logic [2**ADDR_W-1:0] dec_c
);
  localparam int unsigned N = 2**ADDR_W;

  always_comb begin
    dec_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      dec_c[i] = en && (addr == ADDR_W'(i));
    end
    dec_c[REG_ZERO] = 1'b0;
  end
endmodule

// File: rtl/mips_register_file_mux.sv
// Datapath 2:1 word mux (RegDst/MemtoReg style), reused for the read bypass.
module mux2_32 #(
  parameter int unsigned W = mips_pkg::DATA_W
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y_c
);
  assign y_c = sel ? b : a;
endmodule

// File: rtl/mips_register_file.sv
// 32-entry MIPS register file: r0 hard-wired to zero, async clear, combinational reads
// with write-through bypass so a same-cycle write is seen by the reader.
module mips_register_file
  import mips_pkg::REG_ZERO;
#(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  mips_register_file_if.slave bus
);
  localparam int unsigned N = 2**ADDR_W;

  logic [N-1:0]      we;
  logic [DATA_W-1:0] store [1:N-1];
  logic [DATA_W-1:0] sel1;
  logic [DATA_W-1:0] sel2;
  logic              write_live;
  logic              hit1;
  logic              hit2;

  // Reset gates the decoder so no write (or bypass) can occur while rst_n is low.
  decoder_5_to_32 #(.ADDR_W(ADDR_W)) u_dec (
    .en    (bus.reg_write & rst_n),
    .addr  (bus.write_reg),
    .dec_c (we)
  );

  for (genvar i = 1; i < N; i++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        store[i] <= '0;
      end else if (we[i]) begin
        store[i] <= bus.write_data;
      end
    end
  end

  // 32:1 read selection; address zero falls through to the zero default.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    for (int unsigned i = 1; i < N; i++) begin
      if (bus.read_reg1 == ADDR_W'(i)) sel1 = store[i];
      if (bus.read_reg2 == ADDR_W'(i)) sel2 = store[i];
    end
  end

  assign write_live = |we;
  assign hit1       = write_live && (bus.read_reg1 == bus.write_reg)
                      && (bus.write_reg != ADDR_W'(REG_ZERO));
  assign hit2       = write_live && (bus.read_reg2 == bus.write_reg)
                      && (bus.write_reg != ADDR_W'(REG_ZERO));

  mux2_32 #(.W(DATA_W)) u_byp1 (
    .sel (hit1),
    .a   (sel1),
    .b   (bus.write_data),
    .y_c (bus.read_data1)
  );

  mux2_32 #(.W(DATA_W)) u_byp2 (
    .sel (hit2),
    .a   (sel2),
    .b   (bus.write_data),
    .y_c (bus.read_data2)
  );
endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file: reset, r0, bypass, write gating, async reset mid-write.
module tb_mips_register_file;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  mips_register_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  mips_register_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    bus.reg_write  = 1'b0;
    bus.write_reg  = '0;
    bus.write_data = '0;
    bus.read_reg1  = '0;
    bus.read_reg2  = '0;
    #2;

    // Reset held: every address reads zero; attempted writes and bypass are blocked.
    for (int a = 0; a < 32; a++) begin
      bus.reg_write  = 1'b1;
      bus.write_reg  = 5'(a);
      bus.write_data = 32'hFFFF_FFFF;
      bus.read_reg1  = 5'(a);
      bus.read_reg2  = 5'(31 - a);
      #1;
      chk($sformatf("rst_rd1_r%0d", a), bus.read_data1, 32'h0);
      chk($sformatf("rst_rd2_r%0d", 31 - a), bus.read_data2, 32'h0);
    end

    // First edge after release performs the write to r8.
    @(negedge clk);
    rst_n = 1'b1;
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd8;
    bus.write_data = 32'hDEAD_BEEF;
    bus.read_reg1  = 5'd7;
    bus.read_reg2  = 5'd9;
    #1;
    chk("pre_r7", bus.read_data1, 32'h0);
    chk("pre_r9", bus.read_data2, 32'h0);

    @(negedge clk);
    bus.reg_write = 1'b0;
    bus.write_reg = 5'd0;
    bus.read_reg1 = 5'd8;
    bus.read_reg2 = 5'd8;
    #1;
    chk("r8_rd1", bus.read_data1, 32'hDEAD_BEEF);
    chk("r8_rd2", bus.read_data2, 32'hDEAD_BEEF);
    bus.read_reg1 = 5'd7;
    bus.read_reg2 = 5'd9;
    #1;
    chk("r7_zero", bus.read_data1, 32'h0);
    chk("r9_zero", bus.read_data2, 32'h0);
    bus.read_reg1 = 5'd4;
    #1;
    chk("r4_blocked_in_reset", bus.read_data1, 32'h0);

    // Writes to r0 are discarded, including during the write cycle.
    @(negedge clk);
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd0;
    bus.write_data = 32'hFFFF_FFFF;
    bus.read_reg1  = 5'd0;
    bus.read_reg2  = 5'd8;
    #1;
    chk("r0_same_cycle", bus.read_data1, 32'h0);
    chk("r0_wr_r8_kept", bus.read_data2, 32'hDEAD_BEEF);
    @(negedge clk);
    #1;
    chk("r0_next_cycle", bus.read_data1, 32'h0);
    @(negedge clk);
    bus.reg_write = 1'b0;
    #1;
    chk("r0_after", bus.read_data1, 32'h0);

    // Bypass: r5 = 0x11111111, then overwrite with 0x22222222 read in the same cycle.
    @(negedge clk);
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd5;
    bus.write_data = 32'h1111_1111;
    bus.read_reg2  = 5'd5;
    #1;
    chk("byp_first", bus.read_data2, 32'h1111_1111);
    @(negedge clk);
    bus.reg_write  = 1'b0;
    #1;
    chk("r5_stored_1", bus.read_data2, 32'h1111_1111);
    bus.reg_write  = 1'b1;
    bus.write_data = 32'h2222_2222;
    bus.read_reg1  = 5'd5;
    #1;
    chk("byp_rd2", bus.read_data2, 32'h2222_2222);
    chk("byp_rd1_same_reg", bus.read_data1, 32'h2222_2222);
    @(negedge clk);
    bus.reg_write = 1'b0;
    #1;
    chk("r5_stored_2", bus.read_data2, 32'h2222_2222);
    bus.read_reg1 = 5'd5;
    bus.read_reg2 = 5'd8;
    #1;
    chk("indep_rd1", bus.read_data1, 32'h2222_2222);
    chk("indep_rd2", bus.read_data2, 32'hDEAD_BEEF);

    // reg_write=0 leaves r3 untouched and must not bypass.
    @(negedge clk);
    bus.reg_write  = 1'b0;
    bus.write_reg  = 5'd3;
    bus.write_data = 32'h1234_5678;
    bus.read_reg1  = 5'd3;
    #1;
    chk("nowr_same_cycle", bus.read_data1, 32'h0);
    @(negedge clk);
    #1;
    chk("nowr_after_edge", bus.read_data1, 32'h0);

    // Neighbour isolation after writing r9.
    @(negedge clk);
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd9;
    bus.write_data = 32'hCAFE_F00D;
    @(negedge clk);
    bus.reg_write = 1'b0;
    bus.read_reg1 = 5'd9;
    bus.read_reg2 = 5'd10;
    #1;
    chk("r9_written", bus.read_data1, 32'hCAFE_F00D);
    chk("r10_zero", bus.read_data2, 32'h0);
    bus.read_reg2 = 5'd8;
    #1;
    chk("r8_intact", bus.read_data2, 32'hDEAD_BEEF);

    // r31 written, then reset asserted mid-cycle during another write.
    @(negedge clk);
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd31;
    bus.write_data = 32'hA5A5_A5A5;
    @(negedge clk);
    bus.reg_write = 1'b0;
    bus.read_reg1 = 5'd31;
    #1;
    chk("r31_stored", bus.read_data1, 32'hA5A5_A5A5);
    bus.reg_write  = 1'b1;
    bus.write_data = 32'h5A5A_5A5A;
    #1;
    chk("r31_bypass", bus.read_data1, 32'h5A5A_5A5A);
    rst_n = 1'b0;
    #1;
    chk("r31_async_clear", bus.read_data1, 32'h0);
    chk("r8_async_clear", bus.read_data2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.reg_write = 1'b0;
    #1;
    chk("r31_after_release", bus.read_data1, 32'h0);
    chk("r8_after_release", bus.read_data2, 32'h0);
    @(negedge clk);
    #1;
    chk("r31_still_zero", bus.read_data1, 32'h0);
    bus.reg_write  = 1'b1;
    bus.write_data = 32'h1357_9BDF;
    @(negedge clk);
    bus.reg_write = 1'b0;
    #1;
    chk("r31_rewritten", bus.read_data1, 32'h1357_9BDF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
